// File: rtl/acc_sched.sv
// acc_sched: frame scheduler in front of an integrating accumulator.
//
// Forwards a qualified sample stream to an accumulator and marks integration
// boundaries. After arm, the scheduler waits for a valid sample carrying
// sync_in. It then emits a boundary (acc_done) on the first sample of every
// frame of active_len valid samples. A stop request finishes the current
// frame, then issues one flush boundary with no sample.
//
// Ports:
//   clk, rst       : clock and synchronous active-high reset
//   din, din_valid : input sample stream
//   sync_in        : frame-alignment marker (used only while waiting for sync)
//   arm, stop      : single-cycle start / stop requests
//   cfg_len/cfg_we : integration-length write (takes effect at a frame start)
//   acc_din, acc_din_valid, acc_done, acc_first : registered accumulator feed
//   frame_cnt      : integrations completed since arming
//   busy           : scheduler not idle (registered, one cycle behind state)
//   cfg_err        : pulse for a rejected zero-length write
//   fsm_state      : current FSM state, for debug
//
// Handshake: din is consumed in any cycle where din_valid=1; there is no
// back-pressure. Every output is a register, so the outputs for a sample
// appear exactly one cycle after that sample is presented.
module acc_sched #(
  parameter int DIN_WIDTH   = 16,
  parameter int LEN_WIDTH   = 16,
  parameter int DEFAULT_LEN = 1024
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [DIN_WIDTH-1:0] din,
  input  logic                 din_valid,
  input  logic                 sync_in,
  input  logic                 arm,
  input  logic                 stop,
  input  logic [LEN_WIDTH-1:0] cfg_len,
  input  logic                 cfg_we,
  output logic [DIN_WIDTH-1:0] acc_din,
  output logic                 acc_din_valid,
  output logic                 acc_done,
  output logic                 acc_first,
  output logic [31:0]          frame_cnt,
  output logic                 busy,
  output logic                 cfg_err,
  output logic [1:0]           fsm_state
);

  typedef enum logic [1:0] {IDLE = 2'd0, WAIT_SYNC = 2'd1, RUN = 2'd2, FLUSH = 2'd3} state_t;

  localparam logic [LEN_WIDTH-1:0] LEN_ONE = LEN_WIDTH'(1);
  localparam logic [LEN_WIDTH-1:0] LEN_RST = LEN_WIDTH'(DEFAULT_LEN);

  state_t               state, state_nx;
  logic [LEN_WIDTH-1:0] cnt, cnt_nx;
  logic [LEN_WIDTH-1:0] active_len, active_len_nx;
  logic [LEN_WIDTH-1:0] shadow_len;
  logic [LEN_WIDTH-1:0] len_use;
  logic                 stop_pend, stop_pend_nx;
  logic                 valid_nx, done_nx, first_nx;
  logic [31:0]          frame_cnt_nx;
  logic                 boundary, last;

  assign fsm_state = state;

  always_comb begin
    state_nx      = state;
    cnt_nx        = cnt;
    active_len_nx = active_len;
    stop_pend_nx  = stop_pend;
    valid_nx      = 1'b0;
    done_nx       = 1'b0;
    first_nx      = 1'b0;
    frame_cnt_nx  = frame_cnt;
    boundary      = 1'b0;
    len_use       = active_len;
    last          = 1'b0;

    case (state)
      IDLE: begin
        stop_pend_nx = 1'b0;
        if (arm) state_nx = WAIT_SYNC;
      end

      WAIT_SYNC: begin
        if (stop) begin
          state_nx = IDLE;
        end else if (din_valid && sync_in) begin
          // Arming sample: index 0 of the first frame.
          state_nx      = RUN;
          valid_nx      = 1'b1;
          done_nx       = 1'b1;
          first_nx      = 1'b1;
          frame_cnt_nx  = 32'd0;
          active_len_nx = shadow_len;
          cnt_nx        = (shadow_len == LEN_ONE) ? '0 : LEN_ONE;
        end
      end

      RUN: begin
        if (stop) stop_pend_nx = 1'b1;
        if (din_valid) begin
          valid_nx = 1'b1;
          boundary = (cnt == '0);
          // A frame-start sample is counted against the length it loads,
          // so a length-1 frame is both first and last sample.
          len_use  = boundary ? shadow_len : active_len;
          last     = (cnt == len_use - LEN_ONE);
          if (boundary) begin
            done_nx       = 1'b1;
            frame_cnt_nx  = frame_cnt + 32'd1;
            active_len_nx = shadow_len;
          end
          cnt_nx = last ? '0 : cnt + LEN_ONE;
          if (last && (stop || stop_pend)) state_nx = FLUSH;
        end
      end

      FLUSH: begin
        // Boundary with no sample closes the final integration.
        done_nx      = 1'b1;
        frame_cnt_nx = frame_cnt + 32'd1;
        stop_pend_nx = 1'b0;
        cnt_nx       = '0;
        state_nx     = IDLE;
      end

      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= IDLE;
      cnt           <= '0;
      active_len    <= LEN_RST;
      shadow_len    <= LEN_RST;
      stop_pend     <= 1'b0;
      acc_din       <= '0;
      acc_din_valid <= 1'b0;
      acc_done      <= 1'b0;
      acc_first     <= 1'b0;
      frame_cnt     <= 32'd0;
      busy          <= 1'b0;
      cfg_err       <= 1'b0;
    end else begin
      state         <= state_nx;
      cnt           <= cnt_nx;
      active_len    <= active_len_nx;
      stop_pend     <= stop_pend_nx;
      acc_din       <= din;
      acc_din_valid <= valid_nx;
      acc_done      <= done_nx;
      acc_first     <= first_nx;
      frame_cnt     <= frame_cnt_nx;
      busy          <= (state != IDLE);
      cfg_err       <= cfg_we && (cfg_len == '0);
      if (cfg_we && (cfg_len != '0)) shadow_len <= cfg_len;
    end
  end

endmodule
